// File: rtl/dff_delay_line_if.sv
// Bus bundle for dff_delay_line: input word, stall/flush controls and delayed output.
// Optional par_err signal exists only when DFF_DELAY_PARITY_EN is defined.
interface dff_delay_line_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic             en;
   logic             flush;
   logic             d_valid;
   logic [WIDTH-1:0] d;
   logic             q_valid;
   logic [WIDTH-1:0] q;
   logic [CNT_W-1:0] occ;
`ifdef DFF_DELAY_PARITY_EN
   logic             par_err;

   modport master (
      output en, flush, d_valid, d,
      input  q_valid, q, occ, par_err
   );

   modport slave (
      input  en, flush, d_valid, d,
      output q_valid, q, occ, par_err
   );
`else
   modport master (
      output en, flush, d_valid, d,
      input  q_valid, q, occ
   );

   modport slave (
      input  en, flush, d_valid, d,
      output q_valid, q, occ
   );
`endif
endinterface

// File: rtl/dff_delay_line.sv
// DEPTH-stage valid/data delay line with enable stall, synchronous flush and occupancy count.
// Define DFF_DELAY_PARITY_EN to add per-stage even parity and a sticky par_err output.
module dff_delay_line #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input logic             clk,
   input logic             rstn,
   dff_delay_line_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0][WIDTH-1:0] stg_data;
   logic [DEPTH-1:0][WIDTH-1:0] stg_data_nxt;
   logic [DEPTH-1:0]            stg_valid;
   logic [DEPTH-1:0]            stg_valid_nxt;
   logic [CNT_W-1:0]            occ_q;
   logic [CNT_W-1:0]            occ_nxt;
`ifdef DFF_DELAY_PARITY_EN
   logic [DEPTH-1:0]            stg_par;
   logic [DEPTH-1:0]            stg_par_nxt;
   logic                        par_err_q;
   logic                        par_err_nxt;
`endif

   // Next-state: flush beats enable, enable beats hold
   always_comb begin
      stg_data_nxt  = stg_data;
      stg_valid_nxt = stg_valid;
      occ_nxt       = occ_q;
`ifdef DFF_DELAY_PARITY_EN
      stg_par_nxt   = stg_par;
      par_err_nxt   = par_err_q;
`endif
      if (bus.flush) begin
         stg_data_nxt  = '0;
         stg_valid_nxt = '0;
         occ_nxt       = '0;
`ifdef DFF_DELAY_PARITY_EN
         stg_par_nxt   = '0;
         par_err_nxt   = 1'b0;
`endif
      end else if (bus.en) begin
         stg_data_nxt[0]  = bus.d;
         stg_valid_nxt[0] = bus.d_valid;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            stg_data_nxt[i]  = stg_data[i-1];
            stg_valid_nxt[i] = stg_valid[i-1];
         end
         // Entry and exit on the same edge cancel, so the count stays in 0..DEPTH
         occ_nxt = occ_q + CNT_W'(bus.d_valid) - CNT_W'(stg_valid[DEPTH-1]);
`ifdef DFF_DELAY_PARITY_EN
         stg_par_nxt[0] = ^bus.d;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            stg_par_nxt[i] = stg_par[i-1];
         end
         if (stg_valid[DEPTH-1] && ((^stg_data[DEPTH-1]) != stg_par[DEPTH-1])) begin
            par_err_nxt = 1'b1;
         end
`endif
      end
   end

   // Stage registers, cleared asynchronously
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stg_data  <= '0;
         stg_valid <= '0;
         occ_q     <= '0;
`ifdef DFF_DELAY_PARITY_EN
         stg_par   <= '0;
         par_err_q <= 1'b0;
`endif
      end else begin
         stg_data  <= stg_data_nxt;
         stg_valid <= stg_valid_nxt;
         occ_q     <= occ_nxt;
`ifdef DFF_DELAY_PARITY_EN
         stg_par   <= stg_par_nxt;
         par_err_q <= par_err_nxt;
`endif
      end
   end

   assign bus.q       = stg_data[DEPTH-1];
   assign bus.q_valid = stg_valid[DEPTH-1];
   assign bus.occ     = occ_q;
`ifdef DFF_DELAY_PARITY_EN
   assign bus.par_err = par_err_q;
`endif

endmodule

// File: tb/tb_dff_delay_line.sv
// Directed self-checking bench for dff_delay_line (WIDTH=8, DEPTH=4).
// Parity steps run only when DFF_DELAY_PARITY_EN is defined.
module tb_dff_delay_line;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;

   logic clk;
   logic rstn;
   int   checks;
   int   errors;

   dff_delay_line_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bif ();

   dff_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle before sampling
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic en, input logic flush, input logic dv, input logic [7:0] dd);
      bif.en      = en;
      bif.flush   = flush;
      bif.d_valid = dv;
      bif.d       = dd;
   endtask

   task automatic chk_out(input string tag, input logic qv, input logic [7:0] qq, input int occ);
      chk({tag, ".q_valid"}, 32'(bif.q_valid), 32'(qv));
      chk({tag, ".q"},       32'(bif.q),       32'(qq));
      chk({tag, ".occ"},     32'(bif.occ),     32'(occ));
   endtask

   initial begin
      int exp_occ;
      checks = 0;
      errors = 0;

      // Reset held for two edges with a valid word on the input
      rstn = 1'b0;
      drive(1'b1, 1'b0, 1'b1, 8'hFF);
      #1;
      chk_out("rst0", 1'b0, 8'h00, 0);
      tick();
      chk_out("rst1", 1'b0, 8'h00, 0);
      tick();
      chk_out("rst2", 1'b0, 8'h00, 0);
      rstn = 1'b1;

      // Streaming 1..10, then three bubbles to drain
      for (int k = 1; k <= 13; k++) begin
         if (k <= 10) drive(1'b1, 1'b0, 1'b1, 8'(k));
         else         drive(1'b1, 1'b0, 1'b0, 8'h00);
         tick();
         exp_occ = 0;
         for (int j = k - 3; j <= k; j++) if (j >= 1 && j <= 10) exp_occ++;
         if (k >= 4) chk_out($sformatf("stream%0d", k), 1'b1, 8'(k - 3), exp_occ);
         else        chk_out($sformatf("stream%0d", k), 1'b0, 8'h00, exp_occ);
      end

      // Flush with en=1 empties everything
      drive(1'b1, 1'b1, 1'b1, 8'hEE);
      tick();
      chk_out("flush0", 1'b0, 8'h00, 0);

      // Stall: A1, A2, three frozen cycles, then drain
      drive(1'b1, 1'b0, 1'b1, 8'hA1);
      tick();
      drive(1'b1, 1'b0, 1'b1, 8'hA2);
      tick();
      chk_out("stall_in", 1'b0, 8'h00, 2);
      drive(1'b0, 1'b0, 1'b1, 8'hBB);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_out($sformatf("stall%0d", k), 1'b0, 8'h00, 2);
      end
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      tick();
      chk_out("stall_e3", 1'b0, 8'h00, 2);
      tick();
      chk_out("stall_e4", 1'b1, 8'hA1, 2);
      drive(1'b0, 1'b0, 1'b1, 8'hCC);
      tick();
      chk_out("stall_hold", 1'b1, 8'hA1, 2);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      tick();
      chk_out("stall_e5", 1'b1, 8'hA2, 1);
      tick();
      chk_out("stall_e6", 1'b0, 8'h00, 0);

      // Bubbles then flush: the flush-cycle word must be dropped
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      tick();
      drive(1'b1, 1'b0, 1'b1, 8'h11);
      tick();
      chk("bub_occ1", 32'(bif.occ), 32'd1);
      drive(1'b1, 1'b0, 1'b0, 8'h22);
      tick();
      chk("bub_occ2", 32'(bif.occ), 32'd1);
      drive(1'b1, 1'b0, 1'b1, 8'h33);
      tick();
      chk("bub_occ3", 32'(bif.occ), 32'd2);
      drive(1'b1, 1'b1, 1'b1, 8'h44);
      tick();
      chk_out("bub_flush", 1'b0, 8'h00, 0);
      drive(1'b1, 1'b0, 1'b1, 8'h55);
      tick();
      chk_out("post_fl1", 1'b0, 8'h00, 1);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      tick();
      chk_out("post_fl2", 1'b0, 8'h00, 1);
      tick();
      chk_out("post_fl3", 1'b0, 8'h00, 1);
      tick();
      chk_out("post_fl4", 1'b1, 8'h55, 1);

      // Mid-stream asynchronous reset with occ=3 and q_valid=1
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      tick();
      drive(1'b1, 1'b0, 1'b1, 8'h71);
      tick();
      drive(1'b1, 1'b0, 1'b1, 8'h72);
      tick();
      drive(1'b1, 1'b0, 1'b1, 8'h73);
      tick();
      drive(1'b1, 1'b0, 1'b0, 8'h74);
      tick();
      chk_out("pre_arst", 1'b1, 8'h71, 3);
      #2;
      rstn = 1'b0;
      #1;
      chk_out("arst", 1'b0, 8'h00, 0);
      tick();
      chk_out("arst_hold", 1'b0, 8'h00, 0);
      rstn = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      tick();
      chk_out("arst_rel", 1'b0, 8'h00, 0);

`ifdef DFF_DELAY_PARITY_EN
      // Corrupt bit 0 of 8'h5A while it sits in stage 1
      chk("par_init", 32'(bif.par_err), 32'd0);
      drive(1'b1, 1'b0, 1'b1, 8'h5A);
      tick();
      drive(1'b1, 1'b0, 1'b1, 8'h3C);
      tick();
      force dut.stg_data[1][0] = 1'b1;
      @(negedge clk);
      release dut.stg_data[1][0];
      tick();
      tick();
      chk("par_q", 32'(bif.q), 32'h5B);
      chk("par_pre", 32'(bif.par_err), 32'd0);
      tick();
      chk("par_set", 32'(bif.par_err), 32'd1);
      tick();
      chk("par_sticky", 32'(bif.par_err), 32'd1);
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      tick();
      chk("par_flush", 32'(bif.par_err), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
